// File: rtl/wm8731_init_sequencer_if.sv
// Request/acknowledge bundle between the WM8731 init sequencer (master side)
// and the write-only I2C controller (slave side), including the shared
// clock-enable pulse that paces the controller.
interface wm8731_init_sequencer_if;
  logic            i2c_en;
  logic [6:0]      addr;
  logic [1:0][7:0] wdata;
  logic            req;
  logic            ack;

  modport master (output i2c_en, output addr, output wdata, output req, input ack);
  modport slave  (input i2c_en, input addr, input wdata, input req, output ack);
endinterface

// File: rtl/wm8731_init_sequencer.sv
// WM8731 power-up sequencer: waits a power-on delay, then writes a fixed
// 10-entry codec register table through the I2C controller one word per
// req/ack transfer. Also generates the controller's 4x-bit-rate clock enable.
module wm8731_init_sequencer #(
  parameter int unsigned DIV       = 125,
  parameter int unsigned POR_DELAY = 50000,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  wm8731_init_sequencer_if.master bus
);

  localparam int unsigned       DIV_W    = $clog2(DIV);
  localparam int unsigned       DLY_W    = (POR_DELAY > 1) ? $clog2(POR_DELAY) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(POR_DELAY - 1);
  localparam logic [3:0]        IDX_LAST = 4'd9;

  typedef enum logic [1:0] {S_WAIT, S_SEND, S_GAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       index_q, index_d;
  logic [DLY_W-1:0] delay_q, delay_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             i2c_en_q, i2c_en_d;
  logic             req_q, busy_q, done_q;

  // Codec register table: {register address, 9-bit value}. R9 (active) must stay last.
  function automatic logic [15:0] table_word(input logic [3:0] idx);
    logic [6:0] r;
    logic [8:0] v;
    case (idx)
      4'd0:    begin r = 7'd15; v = 9'h000; end  // reset
      4'd1:    begin r = 7'd0;  v = 9'h017; end
      4'd2:    begin r = 7'd1;  v = 9'h017; end
      4'd3:    begin r = 7'd2;  v = 9'h079; end
      4'd4:    begin r = 7'd3;  v = 9'h079; end
      4'd5:    begin r = 7'd4;  v = 9'h012; end
      4'd6:    begin r = 7'd5;  v = 9'h000; end
      4'd7:    begin r = 7'd6;  v = 9'h000; end
      4'd8:    begin r = 7'd7;  v = 9'h002; end  // I2S, 16 bit, slave
      default: begin r = 7'd9;  v = 9'h001; end  // active
    endcase
    return {r, v};
  endfunction

  assign div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
  assign i2c_en_d  = (div_cnt_d == DIV_LAST);

  // Free-running enable divider; runs in every state so the controller always has a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      i2c_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      i2c_en_q  <= i2c_en_d;
    end
  end

  // Next-state logic: delay, send one word, wait one enable tick between words, finish.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    delay_d = delay_q;
    wdata_d = wdata_q;
    case (state_q)
      S_WAIT: begin
        if (delay_q == DLY_LAST) begin
          state_d = S_SEND;
          wdata_d = table_word(index_q);
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end
      S_SEND: begin
        // ack is only trusted on an enable tick; the controller holds it for a full period.
        if (bus.ack && i2c_en_q) begin
          state_d = (index_q == IDX_LAST) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        if (i2c_en_q) begin
          index_d = index_q + 4'd1;
          wdata_d = table_word(index_q + 4'd1);
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        if (start) begin
          index_d = '0;
          delay_d = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // State and registered outputs; req/busy/done follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      index_q <= '0;
      delay_q <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      delay_q <= delay_d;
      wdata_q <= wdata_d;
      req_q   <= (state_d == S_SEND);
      busy_q  <= (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign bus.i2c_en = i2c_en_q;
  assign bus.addr   = DEV_ADDR;
  assign bus.wdata  = wdata_q;
  assign bus.req    = req_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_wm8731_init_sequencer.sv
// Bench for wm8731_init_sequencer: a controller model acks a random number of
// enable ticks after each request; a scoreboard of expected table words is
// filled per run and drained by an independent monitor.
module tb_wm8731_init_sequencer;

  localparam int DIV       = 4;
  localparam int POR_DELAY = 10;

  logic clk;
  logic reset;
  logic start;
  logic busy;
  logic done;

  wm8731_init_sequencer_if bus ();

  wm8731_init_sequencer #(
    .DIV       (DIV),
    .POR_DELAY (POR_DELAY),
    .DEV_ADDR  (7'h1A)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          xfer_cnt = 0;
  bit          rand_mode = 1'b0;
  logic [15:0] sb[$];

  // Register map of the codec bring-up, as a list of (register, value) pairs.
  int unsigned tbl_reg[10] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 9};
  int unsigned tbl_val[10] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h002, 'h001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_run();
    for (int i = 0; i < 10; i++) begin
      sb.push_back(16'((tbl_reg[i] * 512) + tbl_val[i]));
    end
  endfunction

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 500; i++) begin
      if (bus.req) break;
      @(negedge clk);
    end
    chk(name, 32'(bus.req), 32'd1);
  endtask

  task automatic pulse_start();
    push_run();
    xfer_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_busy_set", 32'(busy), 32'd1);
  endtask

  // Controller model: ack spans the enable period ending on the Nth tick after req rose.
  initial begin
    int en_cnt;
    int ack_after;
    bus.ack   = 1'b0;
    en_cnt    = 0;
    ack_after = 3;
    forever begin
      @(negedge clk);
      if (reset || !bus.req) begin
        bus.ack   = 1'b0;
        en_cnt    = 0;
        ack_after = rand_mode ? int'($urandom_range(4, 2)) : 3;
      end else begin
        if (bus.i2c_en) en_cnt++;
        bus.ack = (bus.i2c_en && en_cnt == ack_after) ||
                  (!bus.i2c_en && en_cnt == ack_after - 1);
      end
    end
  end

  // Monitor: drains the scoreboard on each completed transfer and checks handshake rules.
  initial begin
    logic        p_valid, p_req, p_xfer, p_last;
    logic [15:0] p_wdata, exp_w;
    int          since;
    bit          en_seen;
    p_valid = 1'b0; p_req = 1'b0; p_xfer = 1'b0; p_last = 1'b0;
    p_wdata = '0; since = 0; en_seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (p_valid) begin
        if (p_xfer) begin
          chk("req_fall", 32'(bus.req), 32'd0);
          if (p_last) begin
            chk("done_set", 32'(done), 32'd1);
            chk("busy_clr", 32'(busy), 32'd0);
          end else begin
            chk("done_early", 32'(done), 32'd0);
          end
        end else if (p_req) begin
          chk("req_hold", 32'(bus.req), 32'd1);
          chk("wdata_stable", 32'(bus.wdata), 32'(p_wdata));
        end
      end
      p_xfer = 1'b0;
      p_last = 1'b0;
      if (reset) begin
        en_seen = 1'b0;
        since   = 0;
      end else begin
        since++;
        if (bus.i2c_en) begin
          if (en_seen) chk("en_period", 32'(since), 32'(DIV));
          en_seen = 1'b1;
          since   = 0;
        end
        if (bus.req && bus.ack && bus.i2c_en) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: got word %0h, expected no transfer", bus.wdata);
          end else begin
            exp_w = sb.pop_front();
            chk("xfer_word", 32'(bus.wdata), 32'(exp_w));
            chk("xfer_addr", 32'(bus.addr), 32'h1A);
            xfer_cnt++;
            p_last = (sb.size() == 0);
          end
          p_xfer = 1'b1;
        end
      end
      p_valid = !reset;
      p_req   = bus.req;
      p_wdata = bus.wdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int n;
    bit got;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req",    32'(bus.req),    32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_en",     32'(bus.i2c_en), 32'd0);
    chk("rst_wdata",  32'(bus.wdata),  32'd0);
    chk("rst_addr",   32'(bus.addr),   32'h1A);

    // Run 1: fixed 3-tick controller latency, power-on delay measured.
    push_run();
    xfer_cnt = 0;
    reset = 1'b0;
    n = 0;
    got = 1'b0;
    for (int e = 1; e <= 100 && !got; e++) begin
      @(negedge clk);
      if (bus.req) begin
        got = 1'b1;
        n = e;
      end
    end
    chk("por_delay", 32'(n), 32'(POR_DELAY));
    chk("first_word", 32'(bus.wdata), 32'h1E00);
    wait_done("run1_done");
    chk("run1_sb_empty", 32'(sb.size()), 32'd0);
    chk("last_word", 32'(bus.wdata), 32'h1201);
    repeat ($urandom_range(20, 5)) @(negedge clk);
    chk("done_hold", 32'(done), 32'd1);
    chk("done_req_low", 32'(bus.req), 32'd0);
    chk("done_busy_low", 32'(busy), 32'd0);

    // Run 2: restart from DONE, random latency, start pulsed during SEND is ignored.
    rand_mode = 1'b1;
    pulse_start();
    wait_req("run2_req");
    repeat ($urandom_range(2, 0)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_send_busy", 32'(busy), 32'd1);
    chk("start_in_send_done", 32'(done), 32'd0);
    wait_done("run2_done");
    chk("run2_sb_empty", 32'(sb.size()), 32'd0);
    chk("run2_cnt", 32'(xfer_cnt), 32'd10);

    // Run 3: reset in the middle of the fifth transfer, then a full clean run.
    repeat ($urandom_range(10, 1)) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (xfer_cnt == 4 && bus.req) break;
      @(negedge clk);
    end
    chk("run3_reached_xfer5", 32'(xfer_cnt == 4 && bus.req), 32'd1);
    repeat ($urandom_range(2, 0)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_req",  32'(bus.req), 32'd0);
    chk("rst_mid_busy", 32'(busy),    32'd0);
    chk("rst_mid_done", 32'(done),    32'd0);
    sb.delete();
    push_run();
    xfer_cnt = 0;
    repeat ($urandom_range(3, 0)) @(negedge clk);
    reset = 1'b0;
    wait_req("run3_req");
    chk("run3_first_word", 32'(bus.wdata), 32'h1E00);
    wait_done("run3_done");
    chk("run3_sb_empty", 32'(sb.size()), 32'd0);

    // Runs 4-5: random idle time in DONE before each restart.
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(30, 1)) @(negedge clk);
      pulse_start();
      wait_done("runN_done");
      chk("runN_sb_empty", 32'(sb.size()), 32'd0);
    end

    repeat (3 * DIV) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
